// File: rtl/mem_pkg.sv
// Shared store-path definitions: access-size encodings, byte-enable width
// and the packed lane payload that forms the tail of each write-buffer entry.
package mem_pkg;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // A write-buffer entry is {addr, wdata, be}; the address part depends on ADDR_W
    // and is therefore prepended by the owner of the buffer.
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } lane_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store packer: replicates data across byte lanes and builds the
// byte-enable mask. Misaligned half/word detection exists only with STORE_MISALIGN_TRAP_EN.
module store_lane_pack
    import mem_pkg::*;
(
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data,
    input  size_e             size,
    output lane_t             lane,
    output logic              misalign_c,
    output logic              size_err_c
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        lane       = '0;
        misalign_c = 1'b0;
        size_err_c = 1'b0;
        case (size)
            SZ_BYTE: begin
                lane.wdata = {4{data[7:0]}};
                lane.be    = 4'b0001 << addr;
            end
            SZ_HALF: begin
                lane.wdata = {2{data[15:0]}};
                lane.be    = addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
                misalign_c = addr[0];
`endif
            end
            SZ_WORD: begin
                lane.wdata = data;
                lane.be    = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
                misalign_c = (addr != 2'b00);
`endif
            end
            SZ_RSVD: size_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_align.sv
// Store-side lane packer with a DEPTH-entry posted-write buffer in front of the data memory.
// Define STORE_MISALIGN_TRAP_EN to drop misaligned half/word stores and pulse misalign.
module store_align
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              misalign,
    output logic              size_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-3:0] waddr;
        lane_t             lane;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    lane_t lane;
    logic  misalign_c;
    logic  size_err_c;
    logic  push;
    logic  enq;
    logic  pop;

    store_lane_pack u_pack (
        .addr       (req_addr[1:0]),
        .data       (req_data),
        .size       (size_e'(req_size)),
        .lane       (lane),
        .misalign_c (misalign_c),
        .size_err_c (size_err_c)
    );

    // Flow control comes from the registered count only, so a pop never re-opens req_ready in the same cycle.
    assign req_ready = (count != CNT_W'(DEPTH));
    assign mem_valid = (count != '0);

    assign push = req_valid & req_ready;
    assign enq  = push & ~misalign_c & ~size_err_c;
    assign pop  = mem_valid & mem_ready;

    // Head is masked while empty so the port reads zero instead of stale or unwritten storage.
    assign head      = fifo_mem[rd_ptr];
    assign mem_addr  = mem_valid ? {head.waddr, 2'b00} : '0;
    assign mem_wdata = mem_valid ? head.lane.wdata : '0;
    assign mem_be    = mem_valid ? head.lane.be : '0;

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every reader sees the pre-edge value.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            size_err <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            size_err <= push & size_err_c;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign <= push & misalign_c;
`endif
        end
    end

`ifndef STORE_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    // NOTE: the storage array is not reset; the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= {req_addr[ADDR_W-1:2], lane};
    end

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: a scoreboard queue of expected writes is filled
// as stores are accepted and drained by a monitor watching the memory port.
module tb_store_align;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic        size_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    store_align #(.ADDR_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .misalign  (misalign),
        .size_err  (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Any completed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            check("write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("mem_addr", mem_addr, mon_e.addr);
                check("mem_wdata", mem_wdata, mon_e.wdata);
                check("mem_be", 32'(mem_be), 32'(mon_e.be));
            end
        end
    end

    // kind: 0 = enqueued write, 1 = reserved size, 2 = misaligned (trap build)
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input int kind, input logic [31:0] ea, input logic [31:0] ew,
                        input logic [3:0] eb);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted", 32'(req_ready), 32'd1);
        if (kind == 0) sb_q.push_back('{ea, ew, eb});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("size_err_pulse", 32'(size_err), 32'(kind == 1));
        check("misalign_pulse", 32'(misalign), 32'(kind == 2));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b0;
        step(2);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_size_err", 32'(size_err), 32'd0);
        rst = 1'b0;
        step(1);

        // Byte at top lane, one-cycle latency from empty
        mem_ready = 1'b1;
        send(32'h0000_1003, 32'h0000_00A5, SZ_BYTE, 0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
        check("latency_valid", 32'(mem_valid), 32'd1);
        send(32'h0000_1000, 32'h0000_005A, SZ_BYTE, 0, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0001);
        send(32'h0000_1001, 32'hFFFF_FF3C, SZ_BYTE, 0, 32'h0000_1000, 32'h3C3C_3C3C, 4'b0010);
        send(32'h0000_2002, 32'h1234_BEEF, SZ_HALF, 0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        send(32'h0000_2000, 32'h1234_BEEF, SZ_HALF, 0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011);
        send(32'h0000_2004, 32'h1234_BEEF, SZ_WORD, 0, 32'h0000_2004, 32'h1234_BEEF, 4'b1111);
        drain();

        // Back-pressure: two fill the buffer, a third is held, then in-order drain
        mem_ready = 1'b0;
        send(32'h0000_4000, 32'h1111_1111, SZ_WORD, 0, 32'h0000_4000, 32'h1111_1111, 4'b1111);
        check("one_entry_ready", 32'(req_ready), 32'd1);
        send(32'h0000_4004, 32'h2222_2222, SZ_WORD, 0, 32'h0000_4004, 32'h2222_2222, 4'b1111);
        check("full_not_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_addr  = 32'h0000_4008;
        req_data  = 32'h3333_3333;
        req_size  = SZ_WORD;
        step(3);
        check("held_not_ready", 32'(req_ready), 32'd0);
        check("held_valid", 32'(mem_valid), 32'd1);
        check("held_addr", mem_addr, 32'h0000_4000);
        check("held_wdata", mem_wdata, 32'h1111_1111);
        mem_ready = 1'b1;
        step(1);
        check("no_same_cycle_reopen", 32'(req_ready), 32'd1);
        send(32'h0000_4008, 32'h3333_3333, SZ_WORD, 0, 32'h0000_4008, 32'h3333_3333, 4'b1111);
        drain();

        // Full buffer drained while new stores stream in behind it
        mem_ready = 1'b0;
        send(32'h0000_5000, 32'hAAAA_0001, SZ_WORD, 0, 32'h0000_5000, 32'hAAAA_0001, 4'b1111);
        send(32'h0000_5006, 32'h0000_0002, SZ_HALF, 0, 32'h0000_5004, 32'h0002_0002, 4'b1100);
        mem_ready = 1'b1;
        send(32'h0000_5009, 32'h0000_0003, SZ_BYTE, 0, 32'h0000_5008, 32'h0303_0303, 4'b0010);
        send(32'h0000_500C, 32'hAAAA_0004, SZ_WORD, 0, 32'h0000_500C, 32'hAAAA_0004, 4'b1111);
        drain();

        // Misaligned stores
`ifdef STORE_MISALIGN_TRAP_EN
        send(32'h0000_3001, 32'hCAFE_F00D, SZ_WORD, 2, '0, '0, '0);
        check("trap_word_no_write", 32'(mem_valid), 32'd0);
        step(1);
        check("trap_pulse_clear", 32'(misalign), 32'd0);
        send(32'h0000_3003, 32'h0000_ABCD, SZ_HALF, 2, '0, '0, '0);
        check("trap_half_no_write", 32'(mem_valid), 32'd0);
        step(1);
        check("trap_half_clear", 32'(misalign), 32'd0);
`else
        send(32'h0000_3001, 32'hCAFE_F00D, SZ_WORD, 0, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
        send(32'h0000_3003, 32'h0000_ABCD, SZ_HALF, 0, 32'h0000_3000, 32'hABCD_ABCD, 4'b1100);
        drain();
`endif

        // Reserved size is accepted but dropped
        send(32'h0000_3008, 32'h5555_5555, 2'b11, 1, '0, '0, '0);
        check("rsvd_no_write", 32'(mem_valid), 32'd0);
        step(1);
        check("size_err_clear", 32'(size_err), 32'd0);

        // Reset flushes pending entries
        mem_ready = 1'b0;
        send(32'h0000_6000, 32'hDEAD_0001, SZ_WORD, 0, 32'h0000_6000, 32'hDEAD_0001, 4'b1111);
        send(32'h0000_6004, 32'hDEAD_0002, SZ_WORD, 0, 32'h0000_6004, 32'hDEAD_0002, 4'b1111);
        rst = 1'b1;
        step(1);
        check("flush_mem_valid", 32'(mem_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd1);
        check("flush_mem_be", 32'(mem_be), 32'd0);
        sb_q.delete();
        rst       = 1'b0;
        mem_ready = 1'b1;
        step(4);
        check("no_stale_write", 32'(mem_valid), 32'd0);
        send(32'h0000_7002, 32'h0000_0077, SZ_BYTE, 0, 32'h0000_7000, 32'h7777_7777, 4'b0100);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
